dse_epoch_sampler: RTL and testbench
====================================

Name: dse_epoch_sampler

Overview:
Parametrised successor to the single-channel DSE endpoint. Detects the DSE reset handshake and latches epoch and reset vector. It then accumulates NUM_CNT hardened performance-counter increment streams over fixed sampling windows and serialises each window's snapshot to the host side through a valid/ready port. It sits between the core's perf-counter taps and the DSE host bridge, replacing per-cycle DPI pushes with windowed, back-pressured sample records.

Parameters:
NUM_CNT, 8, number of counter channels
INC_W, 6, width of each per-cycle increment
ACC_W, 48, accumulator and snapshot width
WIN_W, 20, window-length counter width
EPOCH_W, 64, epoch width
VEC_W, 36, reset-vector width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high
perf_inc  in  NUM_CNT*INC_W  per-cycle increments, channel i at bits [i*INC_W +: INC_W]
cfg_window  in  WIN_W  window length in cycles; sampled on entry to RECORD
dse_reset_valid  in  1  DSE reset request level
dse_reset_vector  in  VEC_W  restart vector
dse_epoch  in  EPOCH_W  epoch tag
smp_valid  out  1  sample word valid
smp_ready  in  1  host accepts word
smp_idx  out  $clog2(NUM_CNT)  channel index of word
smp_data  out  ACC_W  accumulated count
smp_last  out  1  final word of a window record
smp_epoch  out  EPOCH_W  latched epoch
smp_win_id  out  32  window sequence number within the epoch
rst_vec_q  out  VEC_W  latched reset vector
record_active  out  1  state==RECORD
overrun  out  1  sticky: a window end hit while a drain was busy
n_cycles  out  64  free-running cycle count since reset

Behaviour:
- Reset: all outputs 0; state IDLE; accumulators, shadow bank, counters and flags cleared.
- n_cycles increments every non-reset cycle and wraps at 2^64.
- Edge detection uses a registered copy of dse_reset_valid.
- Rising edge of dse_reset_valid, from any state:
  - latch dse_epoch into smp_epoch;
  - clear accumulators, window counter, smp_win_id and overrun;
  - abort any drain: smp_valid drops next cycle. This is the only case where valid may fall without a handshake;
  - go to HOLD.
- HOLD: wait while dse_reset_valid is high. On its falling edge, latch dse_reset_vector into rst_vec_q, go to ARM.
- ARM: one cycle. Load the window length: cfg_window==0 means 2^WIN_W. Go to RECORD.
- RECORD, every cycle:
  - acc[i] += perf_inc[i], zero-extended;
  - window counter increments;
  - on the last cycle of a window, that cycle's increment is included in the snapshot.
- Window end:
  - If the drain is idle: copy acc into the shadow bank, clear acc (the next cycle starts at 0), increment smp_win_id, start the drain.
  - If the drain is busy: set overrun, discard the window (acc still cleared), smp_win_id still increments.
- Drain:
  - emits words idx 0..NUM_CNT-1 from the shadow bank;
  - a word transfers when smp_valid && smp_ready;
  - smp_valid is registered; the first word is valid the cycle after the window end;
  - data and idx stay stable until the transfer;
  - smp_last=1 on idx NUM_CNT-1; drain goes idle after that transfer;
  - with smp_ready held high, one word per cycle.
- A window end in the same cycle as the final drain handshake counts as idle: no overrun, new drain starts next cycle.
- Reset asserted mid-operation: everything returns to reset values at the next edge.
- IDLE: no accumulation, smp_valid=0.

Optional Feature:
DSE_SAT_EN: when defined, accumulators saturate at 2^ACC_W-1 and hold. When undefined, accumulators wrap modulo 2^ACC_W.

Test Plan:
- Handshake: reset, pulse dse_reset_valid high 3 cycles with epoch=0x55 and vector=0x8000_0000 -> rst_vec_q=0x8000_0000 and smp_epoch=0x55; record_active rises 2 cycles after the falling edge.
- Accumulation: NUM_CNT=8, cfg_window=10, inc[i]=i every cycle, smp_ready=1 -> 8 consecutive words with data=10*i, smp_last on idx 7, smp_win_id=1.
- Backpressure: as above, smp_ready low for 30 cycles -> a window end during the drain sets overrun; window 2 is dropped and window 3 reports smp_win_id=3.
- Mid-drain abort: new dse_reset_valid rising edge during the drain of word 3 -> smp_valid=0 next cycle, accumulators 0, overrun cleared, new epoch latched.
- Wrap/saturation: ACC_W=8, inc=63, cfg_window=5 -> data=59 without DSE_SAT_EN, data=255 with it.
- cfg_window=0: WIN_W=4 -> first record appears after 16 cycles in RECORD.

Source files
------------

// File: rtl/dse_epoch_sampler.sv
// DSE epoch sampler: latches epoch/reset vector on the DSE reset handshake, then
// accumulates per-channel perf increments over fixed windows and drains each window
// as a valid/ready word stream. Define DSE_SAT_EN for saturating accumulators.
module dse_epoch_sampler #(
  parameter int NUM_CNT = 8,
  parameter int INC_W   = 6,
  parameter int ACC_W   = 48,
  parameter int WIN_W   = 20,
  parameter int EPOCH_W = 64,
  parameter int VEC_W   = 36,
  localparam int IDX_W  = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CNT*INC_W-1:0] perf_inc,
  input  logic [WIN_W-1:0]         cfg_window,
  input  logic                     dse_reset_valid,
  input  logic [VEC_W-1:0]         dse_reset_vector,
  input  logic [EPOCH_W-1:0]       dse_epoch,
  output logic                     smp_valid,
  input  logic                     smp_ready,
  output logic [IDX_W-1:0]         smp_idx,
  output logic [ACC_W-1:0]         smp_data,
  output logic                     smp_last,
  output logic [EPOCH_W-1:0]       smp_epoch,
  output logic [31:0]              smp_win_id,
  output logic [VEC_W-1:0]         rst_vec_q,
  output logic                     record_active,
  output logic                     overrun,
  output logic [63:0]              n_cycles
);

  typedef enum logic [1:0] {IDLE, HOLD, ARM, RECORD} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);

  state_t             state_q;
  logic               rv_q;
  logic [63:0]        n_cycles_q;
  logic [WIN_W-1:0]   win_cnt_q;
  logic [WIN_W-1:0]   win_last_q;
  logic [31:0]        win_seq_q;
  logic [31:0]        smp_win_id_q;
  logic [EPOCH_W-1:0] smp_epoch_q;
  logic               overrun_q;
  logic               smp_valid_q;
  logic               smp_last_q;
  logic [IDX_W-1:0]   smp_idx_q;
  logic [ACC_W-1:0]   smp_data_q;
  logic [ACC_W-1:0]   acc_q    [NUM_CNT];
  logic [ACC_W-1:0]   shadow_q [NUM_CNT];
  logic [ACC_W-1:0]   acc_d    [NUM_CNT];
  logic [ACC_W:0]     acc_sum;

  logic             rise;
  logic             win_end;
  logic             drain_free;
  logic             xfer;
  logic [IDX_W-1:0] idx_nxt;

  assign rise       = dse_reset_valid && !rv_q;
  assign win_end    = (state_q == RECORD) && (win_cnt_q == win_last_q);
  assign xfer       = smp_valid_q && smp_ready;
  // The final handshake frees the shadow bank in the same cycle a window may end.
  assign drain_free = !smp_valid_q || (xfer && smp_last_q);
  assign idx_nxt    = smp_idx_q + 1'b1;

  // NOTE: combinational blocks give every target a value on every pass
  // (acc_sum first, then acc_d per channel) so no latch is inferred.
  always_comb begin
    acc_sum = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      acc_sum = {1'b0, acc_q[i]} + (ACC_W+1)'(perf_inc[i*INC_W +: INC_W]);
`ifdef DSE_SAT_EN
      acc_d[i] = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
`else
      acc_d[i] = acc_sum[ACC_W-1:0];
`endif
    end
  end

  // NOTE: state is updated only with non-blocking assignments; later assignments
  // in this block deliberately override earlier ones (abort beats handshake, etc.).
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      rv_q         <= 1'b0;
      n_cycles_q   <= '0;
      win_cnt_q    <= '0;
      win_last_q   <= '0;
      win_seq_q    <= '0;
      smp_win_id_q <= '0;
      smp_epoch_q  <= '0;
      overrun_q    <= 1'b0;
      smp_valid_q  <= 1'b0;
      smp_last_q   <= 1'b0;
      smp_idx_q    <= '0;
      smp_data_q   <= '0;
      rst_vec_q    <= '0;
      // NOTE: the accumulator and shadow banks are small flop arrays, not RAM,
      // so they are cleared by reset like any other register.
      for (int i = 0; i < NUM_CNT; i++) begin
        acc_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      rv_q       <= dse_reset_valid;
      n_cycles_q <= n_cycles_q + 64'd1;

      if (rise) begin
        smp_epoch_q  <= dse_epoch;
        win_cnt_q    <= '0;
        win_seq_q    <= '0;
        smp_win_id_q <= '0;
        overrun_q    <= 1'b0;
        smp_valid_q  <= 1'b0;
        smp_last_q   <= 1'b0;
        state_q      <= HOLD;
        for (int i = 0; i < NUM_CNT; i++) acc_q[i] <= '0;
      end else begin
        if (xfer) begin
          smp_valid_q <= !smp_last_q;
          if (!smp_last_q) begin
            smp_idx_q  <= idx_nxt;
            smp_data_q <= shadow_q[idx_nxt];
            smp_last_q <= (idx_nxt == LAST_IDX);
          end
        end

        case (state_q)
          IDLE: ;
          HOLD: begin
            if (!dse_reset_valid) begin
              rst_vec_q <= dse_reset_vector;
              state_q   <= ARM;
            end
          end
          ARM: begin
            // cfg_window == 0 wraps to all-ones, i.e. a window of 2^WIN_W cycles.
            win_last_q <= cfg_window - 1'b1;
            win_cnt_q  <= '0;
            state_q    <= RECORD;
          end
          RECORD: begin
            if (win_end) begin
              win_cnt_q <= '0;
              win_seq_q <= win_seq_q + 32'd1;
              for (int i = 0; i < NUM_CNT; i++) acc_q[i] <= '0;
              if (drain_free) begin
                for (int i = 0; i < NUM_CNT; i++) shadow_q[i] <= acc_d[i];
                smp_valid_q  <= 1'b1;
                smp_idx_q    <= '0;
                smp_data_q   <= acc_d[0];
                smp_last_q   <= (NUM_CNT == 1);
                smp_win_id_q <= win_seq_q + 32'd1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              win_cnt_q <= win_cnt_q + 1'b1;
              for (int i = 0; i < NUM_CNT; i++) acc_q[i] <= acc_d[i];
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign smp_valid     = smp_valid_q;
  assign smp_idx       = smp_idx_q;
  assign smp_data      = smp_data_q;
  assign smp_last      = smp_last_q;
  assign smp_epoch     = smp_epoch_q;
  assign smp_win_id    = smp_win_id_q;
  assign record_active = (state_q == RECORD);
  assign overrun       = overrun_q;
  assign n_cycles      = n_cycles_q;

endmodule

// File: tb/tb_dse_epoch_sampler.sv
// Scoreboard bench for dse_epoch_sampler: a default-size instance (A) and a
// narrow instance (B: ACC_W=8, WIN_W=4, NUM_CNT=2) for wrap/saturation and cfg_window=0.
module tb_dse_epoch_sampler;

  typedef struct {
    logic [3:0]  idx;
    logic [47:0] data;
    logic        last;
    logic [31:0] win;
    logic [63:0] epoch;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- instance A ----------------
  logic [47:0] inc_a = '0;
  logic [19:0] cfg_a = '0;
  logic        dv_a = 1'b0;
  logic [35:0] vec_a = '0;
  logic [63:0] ep_a = '0;
  logic        smp_valid_a, smp_ready_a, smp_last_a, rec_a, ovr_a;
  logic [2:0]  smp_idx_a;
  logic [47:0] smp_data_a;
  logic [63:0] smp_epoch_a, ncyc_a;
  logic [31:0] win_id_a;
  logic [35:0] rvec_a;
  int          pending_a = 0;
  exp_t        exp_a[$];

  assign smp_ready_a = (pending_a != 0);

  dse_epoch_sampler dut_a (
    .clock(clock), .reset(reset), .perf_inc(inc_a), .cfg_window(cfg_a),
    .dse_reset_valid(dv_a), .dse_reset_vector(vec_a), .dse_epoch(ep_a),
    .smp_valid(smp_valid_a), .smp_ready(smp_ready_a), .smp_idx(smp_idx_a),
    .smp_data(smp_data_a), .smp_last(smp_last_a), .smp_epoch(smp_epoch_a),
    .smp_win_id(win_id_a), .rst_vec_q(rvec_a), .record_active(rec_a),
    .overrun(ovr_a), .n_cycles(ncyc_a)
  );

  // ---------------- instance B ----------------
  logic [11:0] inc_b = '0;
  logic [3:0]  cfg_b = '0;
  logic        dv_b = 1'b0;
  logic [35:0] vec_b = '0;
  logic [63:0] ep_b = '0;
  logic        smp_valid_b, smp_ready_b, smp_last_b, rec_b, ovr_b;
  logic [0:0]  smp_idx_b;
  logic [7:0]  smp_data_b;
  logic [63:0] smp_epoch_b, ncyc_b;
  logic [31:0] win_id_b;
  logic [35:0] rvec_b;
  int          pending_b = 0;
  exp_t        exp_b[$];

  assign smp_ready_b = (pending_b != 0);

  dse_epoch_sampler #(.NUM_CNT(2), .INC_W(6), .ACC_W(8), .WIN_W(4)) dut_b (
    .clock(clock), .reset(reset), .perf_inc(inc_b), .cfg_window(cfg_b),
    .dse_reset_valid(dv_b), .dse_reset_vector(vec_b), .dse_epoch(ep_b),
    .smp_valid(smp_valid_b), .smp_ready(smp_ready_b), .smp_idx(smp_idx_b),
    .smp_data(smp_data_b), .smp_last(smp_last_b), .smp_epoch(smp_epoch_b),
    .smp_win_id(win_id_b), .rst_vec_q(rvec_b), .record_active(rec_b),
    .overrun(ovr_b), .n_cycles(ncyc_b)
  );

`ifdef DSE_SAT_EN
  localparam logic [47:0] B_W5_CH0 = 48'd255;   // 5*63 saturates
  localparam logic [47:0] B_W0_CH0 = 48'd255;   // 16*63 saturates
`else
  localparam logic [47:0] B_W5_CH0 = 48'd59;    // 315 mod 256
  localparam logic [47:0] B_W0_CH0 = 48'd240;   // 1008 mod 256
`endif

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic push(input bit b, input int idx, input logic [47:0] data, input logic last,
                      input logic [31:0] win, input logic [63:0] ep);
    exp_t e;
    e.idx = 4'(idx); e.data = data; e.last = last; e.win = win; e.epoch = ep;
    if (b) begin exp_b.push_back(e); pending_b++; end
    else   begin exp_a.push_back(e); pending_a++; end
  endtask

  // Window of A with inc[i]=i and cfg_window=10: channel i totals 10*i.
  task automatic push_win_a(input logic [31:0] win, input logic [63:0] ep);
    for (int i = 0; i < 8; i++) push(1'b0, i, 48'(10 * i), i == 7, win, ep);
  endtask

  task automatic wait_drained(input bit b, input int budget, input string nm);
    int n = 0;
    while (((b ? pending_b : pending_a) != 0) && n < budget) begin
      @(negedge clock); n++;
    end
    check(nm, 64'(b ? pending_b : pending_a), 64'd0);
  endtask

  // Caller sits at a negedge; valid is high for n cycles then dropped.
  task automatic pulse(input bit b, input logic [63:0] ep, input logic [35:0] vec, input int n);
    if (b) begin ep_b = ep; vec_b = vec; dv_b = 1'b1; end
    else   begin ep_a = ep; vec_a = vec; dv_a = 1'b1; end
    repeat (n) @(negedge clock);
    if (b) dv_b = 1'b0; else dv_a = 1'b0;
  endtask

  // Monitors: a word is compared when valid&&ready is seen at the negedge; the
  // pending count drops only after the edge that completes the transfer.
  always begin
    exp_t e;
    @(negedge clock);
    if (smp_valid_a && smp_ready_a) begin
      e = exp_a.pop_front();
      check("a_idx",   64'(smp_idx_a),   64'(e.idx));
      check("a_data",  64'(smp_data_a),  64'(e.data));
      check("a_last",  64'(smp_last_a),  64'(e.last));
      check("a_winid", 64'(win_id_a),    64'(e.win));
      check("a_epoch", smp_epoch_a,      e.epoch);
      @(posedge clock); #1;
      pending_a--;
    end
  end

  always begin
    exp_t e;
    @(negedge clock);
    if (smp_valid_b && smp_ready_b) begin
      e = exp_b.pop_front();
      check("b_idx",   64'(smp_idx_b),   64'(e.idx));
      check("b_data",  64'(smp_data_b),  64'(e.data));
      check("b_last",  64'(smp_last_b),  64'(e.last));
      check("b_winid", 64'(win_id_b),    64'(e.win));
      check("b_epoch", smp_epoch_b,      e.epoch);
      @(posedge clock); #1;
      pending_b--;
    end
  end

  initial begin
    repeat (20000) @(posedge clock);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clock);
    check("rst_valid",   64'(smp_valid_a), 64'd0);
    check("rst_overrun", 64'(ovr_a),       64'd0);
    check("rst_record",  64'(rec_a),       64'd0);
    check("rst_ncyc",    ncyc_a,           64'd0);
    check("rst_epoch",   smp_epoch_a,      64'd0);
    check("rst_vec",     64'(rvec_a),      64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("ncyc_after5", ncyc_a, 64'd5);

    // Handshake + accumulation: inc[i]=i, window 10
    for (int i = 0; i < 8; i++) inc_a[i*6 +: 6] = 6'(i);
    cfg_a = 20'd10;
    pulse(1'b0, 64'h55, 36'h8000_0000, 3);
    @(negedge clock);
    check("hs_vec",     64'(rvec_a), 64'h8000_0000);
    check("hs_epoch",   smp_epoch_a, 64'h55);
    check("hs_rec_arm", 64'(rec_a),  64'd0);
    @(negedge clock);
    check("hs_rec_on",  64'(rec_a),  64'd1);
    push_win_a(32'd1, 64'h55);
    wait_drained(1'b0, 60, "acc_drain_timeout");

    // Backpressure: host takes nothing until window 2 has been dropped
    pulse(1'b0, 64'h66, 36'h123, 2);
    n = 0;
    while (!ovr_a && n < 80) begin @(negedge clock); n++; end
    check("bp_overrun_set", 64'(ovr_a), 64'd1);
    check("bp_stall_valid", 64'(smp_valid_a), 64'd1);
    check("bp_stall_idx",   64'(smp_idx_a),   64'd0);
    push_win_a(32'd1, 64'h66);
    push_win_a(32'd3, 64'h66);
    wait_drained(1'b0, 100, "bp_drain_timeout");
    check("bp_overrun_sticky", 64'(ovr_a), 64'd1);

    // Mid-drain abort while word 3 is stalled and overrun is set
    pulse(1'b0, 64'h77, 36'h1, 2);
    for (int i = 0; i < 3; i++) push(1'b0, i, 48'(10 * i), 1'b0, 32'd1, 64'h77);
    wait_drained(1'b0, 60, "ab_words_timeout");
    n = 0;
    while (!ovr_a && n < 60) begin @(negedge clock); n++; end
    check("ab_pre_overrun", 64'(ovr_a),       64'd1);
    check("ab_pre_idx",     64'(smp_idx_a),   64'd3);
    check("ab_pre_valid",   64'(smp_valid_a), 64'd1);
    ep_a = 64'h88; vec_a = 36'h2; dv_a = 1'b1;
    @(negedge clock);
    check("ab_valid_drop", 64'(smp_valid_a), 64'd0);
    check("ab_overrun_clr", 64'(ovr_a),      64'd0);
    check("ab_epoch",      smp_epoch_a,      64'h88);
    check("ab_winid_clr",  64'(win_id_a),    64'd0);
    repeat (2) @(negedge clock);
    dv_a = 1'b0;
    push_win_a(32'd1, 64'h88);
    wait_drained(1'b0, 60, "ab_fresh_timeout");

    // Reset asserted mid-operation
    n = 0;
    while (!smp_valid_a && n < 40) begin @(negedge clock); n++; end
    reset = 1'b1;
    @(negedge clock);
    check("mr_valid",  64'(smp_valid_a), 64'd0);
    check("mr_record", 64'(rec_a),       64'd0);
    check("mr_ncyc",   ncyc_a,           64'd0);
    check("mr_epoch",  smp_epoch_a,      64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Narrow instance: wrap/saturation with window 5 (ch0 inc 63, ch1 inc 10)
    inc_b = {6'd10, 6'd63};
    cfg_b = 4'd5;
    pulse(1'b1, 64'h1, 36'h9, 2);
    push(1'b1, 0, B_W5_CH0, 1'b0, 32'd1, 64'h1);
    push(1'b1, 1, 48'd50,   1'b1, 32'd1, 64'h1);
    wait_drained(1'b1, 60, "b_w5_timeout");

    // cfg_window=0 on WIN_W=4: first record 16 cycles into RECORD
    cfg_b = 4'd0;
    pulse(1'b1, 64'h2, 36'hA, 2);
    push(1'b1, 0, B_W0_CH0, 1'b0, 32'd1, 64'h2);
    push(1'b1, 1, 48'd160,  1'b1, 32'd1, 64'h2);
    n = 0;
    while (!rec_b && n < 10) begin @(negedge clock); n++; end
    check("b_w0_record", 64'(rec_b), 64'd1);
    n = 0;
    while (!smp_valid_b && n < 40) begin @(negedge clock); n++; end
    check("b_w0_latency", 64'(n), 64'd16);
    wait_drained(1'b1, 60, "b_w0_timeout");

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
